// File: rtl/moving_sum.sv
// Boxcar accumulator: running signed sum of the last 2**LOG2N accepted samples.
// Build option MOVING_SUM_EARLY_VALID_EN: out_valid also pulses for partial sums while filling.
module moving_sum #(
    parameter int IW    = 12,
    parameter int LOG2N = 4,
    localparam int OW   = IW + LOG2N
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [IW-1:0] in,
    output logic          out_valid,
    output logic [OW-1:0] out,
    output logic          full
);

    localparam int N     = 2 ** LOG2N;
    localparam int CNT_W = LOG2N + 1;

    typedef enum logic {FILL, RUN} state_e;

    state_e             state_q, state_d;
    logic [LOG2N-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OW-1:0]      acc_q, acc_d;
    logic               out_valid_q, out_valid_d;
    logic [IW-1:0]      mem_q [N];

    logic               accept;
    logic [IW-1:0]      old_sample;

    assign accept = in_valid && !clear;

    // Stale buffer contents are masked while filling, so the buffer never needs clearing.
    assign old_sample = (state_q == RUN) ? mem_q[wr_ptr_q] : '0;

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = FILL;
        end else if (in_valid && state_q == FILL && cnt_q == CNT_W'(N - 1)) begin
            state_d = RUN;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        if (clear) begin
            wr_ptr_d = '0;
            cnt_d    = '0;
            acc_d    = '0;
        end else if (in_valid) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (cnt_q != CNT_W'(N)) begin
                cnt_d = cnt_q + 1'b1;
            end
            acc_d = acc_q + {{LOG2N{in[IW-1]}}, in}
                          - {{LOG2N{old_sample[IW-1]}}, old_sample};
        end
    end

    always_comb begin
`ifdef MOVING_SUM_EARLY_VALID_EN
        out_valid_d = accept;
`else
        out_valid_d = accept && (state_d == RUN);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= in;
        end
    end

    assign out       = acc_q;
    assign out_valid = out_valid_q;
    assign full      = (state_q == RUN);

endmodule

// File: tb/tb_moving_sum.sv
// Self-checking bench for moving_sum against a queue-based window-sum model.
module tb_moving_sum;

    localparam int IW    = 12;
    localparam int LOG2N = 4;
    localparam int OW    = IW + LOG2N;
    localparam int N     = 2 ** LOG2N;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in = '0;
    logic          out_valid;
    logic [OW-1:0] out;
    logic          full;

    int errors = 0;
    int checks = 0;

    int win[$];
    int exp_out = 0;
    bit exp_vld = 1'b0;
    int vld_count = 0;

    moving_sum #(.IW(IW), .LOG2N(LOG2N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in        (in),
        .out_valid (out_valid),
        .out       (out),
        .full      (full)
    );

    always #5 clk = ~clk;

    function automatic int out_s();
        return int'($signed(out));
    endfunction

    function automatic int window_sum();
        int s = 0;
        foreach (win[i]) s += win[i];
        return s;
    endfunction

    task automatic model_reset();
        win.delete();
        exp_out = 0;
        exp_vld = 1'b0;
    endtask

    // Drive one cycle, advance the model, and compare all outputs just after the edge.
    task automatic step(input bit v, input bit c, input int x, input string tag);
        in_valid = v;
        clear    = c;
        in       = IW'(x);
        @(posedge clk);
        #1;
        if (c) begin
            model_reset();
        end else if (v) begin
            win.push_back(x);
            if (win.size() > N) void'(win.pop_front());
            exp_out = window_sum();
`ifdef MOVING_SUM_EARLY_VALID_EN
            exp_vld = 1'b1;
`else
            exp_vld = (win.size() == N);
`endif
        end else begin
            exp_vld = 1'b0;
        end
        if (out_valid) vld_count++;
        checks += 3;
        if (out_s() !== exp_out) begin
            errors++;
            $display("FAIL %s out: got %0d expected %0d", tag, out_s(), exp_out);
        end
        if (out_valid !== exp_vld) begin
            errors++;
            $display("FAIL %s out_valid: got %0b expected %0b", tag, out_valid, exp_vld);
        end
        if (full !== (win.size() == N)) begin
            errors++;
            $display("FAIL %s full: got %0b expected %0b", tag, full, win.size() == N);
        end
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks += 3;
        if (out !== '0) begin
            errors++;
            $display("FAIL reset out: got %0d expected 0", out_s());
        end
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset out_valid: got %0b expected 0", out_valid);
        end
        if (full !== 1'b0) begin
            errors++;
            $display("FAIL reset full: got %0b expected 0", full);
        end
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_fill_ones();
        for (int i = 0; i < N + 1; i++) step(1'b1, 1'b0, 1, "fill_ones");
        checks++;
        if (out_s() !== 16) begin
            errors++;
            $display("FAIL fill_ones_final: got %0d expected 16", out_s());
        end
    endtask

    task automatic test_drain_zeros();
        for (int i = 0; i < N; i++) step(1'b1, 1'b0, 0, "drain_zeros");
        checks++;
        if (out_s() !== 0) begin
            errors++;
            $display("FAIL drain_zeros_final: got %0d expected 0", out_s());
        end
    endtask

    task automatic test_extremes();
        for (int i = 0; i < N; i++) step(1'b1, 1'b0, -2048, "extreme_neg");
        checks++;
        if (out_s() !== -32768) begin
            errors++;
            $display("FAIL extreme_neg_final: got %0d expected -32768", out_s());
        end
        for (int i = 0; i < N; i++) step(1'b1, 1'b0, 2047, "extreme_pos");
        checks++;
        if (out_s() !== 32752) begin
            errors++;
            $display("FAIL extreme_pos_final: got %0d expected 32752", out_s());
        end
    endtask

    task automatic test_gapped();
        step(1'b0, 1'b1, 0, "gapped_clear");
        vld_count = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 1'b0, k, "gapped");
            step(1'b0, 1'b0, 0, "gapped_idle");
            step(1'b0, 1'b0, 0, "gapped_idle");
        end
        checks += 2;
        if (out_s() !== 200) begin
            errors++;
            $display("FAIL gapped_final: got %0d expected 200", out_s());
        end
`ifdef MOVING_SUM_EARLY_VALID_EN
        if (vld_count !== 20) begin
            errors++;
            $display("FAIL gapped_vld_count: got %0d expected 20", vld_count);
        end
`else
        if (vld_count !== 5) begin
            errors++;
            $display("FAIL gapped_vld_count: got %0d expected 5", vld_count);
        end
`endif
    endtask

    task automatic test_clear();
        step(1'b1, 1'b1, 777, "clear_mid_run");
        checks++;
        if (out !== '0 || full !== 1'b0) begin
            errors++;
            $display("FAIL clear_mid_run_direct: got out=%0d full=%0b expected out=0 full=0", out_s(), full);
        end
        for (int i = 0; i < N; i++) step(1'b1, 1'b0, 3, "refill");
        checks++;
        if (out_s() !== 48) begin
            errors++;
            $display("FAIL refill_final: got %0d expected 48", out_s());
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < N + 3; i++) step(1'b1, 1'b0, 100 + i, "pre_async");
        in_valid = 1'b1;
        in       = IW'(9);
        #2 rst_n = 1'b0;
        #1;
        checks += 3;
        if (out !== '0) begin
            errors++;
            $display("FAIL async_reset out: got %0d expected 0", out_s());
        end
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset out_valid: got %0b expected 0", out_valid);
        end
        if (full !== 1'b0) begin
            errors++;
            $display("FAIL async_reset full: got %0b expected 0", full);
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
        step(1'b1, 1'b0, 5, "after_async");
`ifdef MOVING_SUM_EARLY_VALID_EN
        checks++;
        if (out_valid !== 1'b1 || out_s() !== 5 || full !== 1'b0) begin
            errors++;
            $display("FAIL early_first: got vld=%0b out=%0d full=%0b expected 1 5 0", out_valid, out_s(), full);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int x;
            x = $signed(IW'($urandom));
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 60) == 0), x, "random");
        end
    endtask

    initial begin
        test_reset();
        test_fill_ones();
        test_drain_zeros();
        test_extremes();
        test_gapped();
        test_clear();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
